// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM duty-ramp sequencer.
package pwm_ramp_pkg;

   localparam int DUTY_W_DEF = 12;
   localparam int DIV_W_DEF  = 8;
   localparam int DUTY_MAX   = 4095;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Per-channel configuration record as written by the register file.
   typedef struct packed {
      logic [DUTY_W_DEF-1:0] target;
      logic [DUTY_W_DEF-1:0] step;
      logic [DIV_W_DEF-1:0]  div;
   } ch_cfg_t;

endpackage

// File: rtl/pwm_ramp_step.sv
// Saturating one-step move of a duty value toward its target.
// step == 0 means jump straight to target; moves never overshoot, wrap or underflow.
module pwm_ramp_step #(
   parameter int DUTY_W = 12
) (
   input  logic [DUTY_W-1:0] cur,
   input  logic [DUTY_W-1:0] target,
   input  logic [DUTY_W-1:0] step,
   output logic [DUTY_W-1:0] next_cur,
   output logic              reached
);

   logic [DUTY_W:0] sum_ext;
   logic [DUTY_W:0] diff_ext;

   assign sum_ext  = {1'b0, cur} + {1'b0, step};
   assign diff_ext = {1'b0, cur} - {1'b0, step};

   // Pick the clamped result; the extra MSB catches overflow past full scale and borrow below zero.
   always_comb begin
      next_cur = cur;
      if (step == '0) begin
         next_cur = target;
      end else if (cur < target) begin
         next_cur = (sum_ext >= {1'b0, target}) ? target : sum_ext[DUTY_W-1:0];
      end else if (cur > target) begin
         next_cur = (diff_ext[DUTY_W] || (diff_ext[DUTY_W-1:0] <= target)) ? target
                                                                           : diff_ext[DUTY_W-1:0];
      end
   end

   assign reached = (next_cur == target);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Multi-channel duty-ramp controller. Once per PWM period it walks all channels
// through a single shared step unit, then publishes every duty together.
// Optional build macro PWM_RAMP_HOLD_EN adds a 'hold' input that freezes a whole sweep.
//
// state  | meaning
// IDLE   | waiting for period_tick; config writes accepted here only
// SWEEP  | updating channel idx this cycle
// COMMIT | copy all cur values to duty_out, pulse ramp_done
module pwm_ramp_sequencer
   import pwm_ramp_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     period_tick,
`ifdef PWM_RAMP_HOLD_EN
   input  logic                     hold,
`endif
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [3:0]               cfg_ch,
   input  logic [DUTY_W-1:0]        cfg_target,
   input  logic [DUTY_W-1:0]        cfg_step,
   input  logic [DIV_W-1:0]         cfg_div,
   output logic [NUM_CH*DUTY_W-1:0] duty_out,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        ramp_done,
   output logic                     cfg_err,
   output logic                     overrun
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  idx;

   logic [DUTY_W-1:0] cur_q [NUM_CH];
   logic [DUTY_W-1:0] tgt_q [NUM_CH];
   logic [DUTY_W-1:0] stp_q [NUM_CH];
   logic [DIV_W-1:0]  div_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_q [NUM_CH];
   logic [NUM_CH-1:0] done_acc;

   logic              cfg_fire;
   logic              cfg_ch_ok;
   logic              sweep_hold;

   logic [DUTY_W-1:0] sel_cur;
   logic [DUTY_W-1:0] sel_tgt;
   logic [DUTY_W-1:0] sel_stp;
   logic [DIV_W-1:0]  sel_div;
   logic [DIV_W-1:0]  sel_cnt;
   logic [DUTY_W-1:0] mv_cur;
   logic              mv_reached;

   assign cfg_fire  = cfg_valid && cfg_ready;
   assign cfg_ch_ok = ({1'b0, cfg_ch} < 5'(NUM_CH));

`ifdef PWM_RAMP_HOLD_EN
   logic hold_q;

   // Hold is sampled once at sweep entry so a sweep is either fully frozen or fully live.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_q <= 1'b0;
      end else if ((state == IDLE) && period_tick) begin
         hold_q <= hold;
      end
   end

   assign sweep_hold = hold_q;
`else
   assign sweep_hold = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; ticks outside IDLE are dropped and never change the walk.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (period_tick) state_nxt = SWEEP;
         SWEEP:   if (idx == LAST_IDX) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      cfg_ready = (state == IDLE);
   end

   // Select the channel being swept for the shared step unit.
   always_comb begin
      sel_cur = '0;
      sel_tgt = '0;
      sel_stp = '0;
      sel_div = '0;
      sel_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_cur = cur_q[i];
            sel_tgt = tgt_q[i];
            sel_stp = stp_q[i];
            sel_div = div_q[i];
            sel_cnt = cnt_q[i];
         end
      end
   end

   pwm_ramp_step #(
      .DUTY_W (DUTY_W)
   ) u_step (
      .cur      (sel_cur),
      .target   (sel_tgt),
      .step     (sel_stp),
      .next_cur (mv_cur),
      .reached  (mv_reached)
   );

   // Channel registers, sweep updates, commit and event pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cur_q[i] <= '0;
            tgt_q[i] <= '0;
            stp_q[i] <= '0;
            div_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         idx       <= '0;
         done_acc  <= '0;
         duty_out  <= '0;
         busy      <= '0;
         ramp_done <= '0;
         cfg_err   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         ramp_done <= '0;
         cfg_err   <= 1'b0;
         overrun   <= period_tick && (state != IDLE);
         case (state)
            IDLE: begin
               idx      <= '0;
               done_acc <= '0;
               if (cfg_fire) begin
                  cfg_err <= !cfg_ch_ok;
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (cfg_ch_ok && (cfg_ch == 4'(i))) begin
                        tgt_q[i] <= cfg_target;
                        stp_q[i] <= cfg_step;
                        div_q[i] <= cfg_div;
                        cnt_q[i] <= '0;
                        busy[i]  <= (cur_q[i] != cfg_target);
                     end
                  end
               end
            end
            SWEEP: begin
               if (idx != LAST_IDX) begin
                  idx <= idx + IDX_W'(1);
               end
               if (!sweep_hold) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (idx == IDX_W'(i)) begin
                        if (sel_cnt != sel_div) begin
                           cnt_q[i] <= sel_cnt + DIV_W'(1);
                        end else begin
                           cnt_q[i] <= '0;
                           cur_q[i] <= mv_cur;
                           busy[i]  <= (mv_cur != sel_tgt);
                           if (mv_reached && (sel_cur != sel_tgt)) begin
                              done_acc[i] <= 1'b1;
                           end
                        end
                     end
                  end
               end
            end
            COMMIT: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  duty_out[i*DUTY_W +: DUTY_W] <= cur_q[i];
               end
               ramp_done <= done_acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with a reference model and expected-result queue.
module tb_pwm_ramp_sequencer;

   localparam int NUM_CH = 4;
   localparam int DW     = 12;
   localparam int VW     = NUM_CH * DW;

   logic          clock;
   logic          reset;
   logic          period_tick;
`ifdef PWM_RAMP_HOLD_EN
   logic          hold;
`endif
   logic          cfg_valid;
   logic          cfg_ready;
   logic [3:0]    cfg_ch;
   logic [DW-1:0] cfg_target;
   logic [DW-1:0] cfg_step;
   logic [7:0]    cfg_div;
   logic [VW-1:0] duty_out;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] ramp_done;
   logic          cfg_err;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   int m_cur [NUM_CH];
   int m_tgt [NUM_CH];
   int m_stp [NUM_CH];
   int m_div [NUM_CH];
   int m_cnt [NUM_CH];
   bit m_hold = 1'b0;

   logic [VW-1:0]     exp_q  [$];
   logic [NUM_CH-1:0] done_q [$];

   pwm_ramp_sequencer #(.NUM_CH(NUM_CH), .DUTY_W(DW), .DIV_W(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .period_tick (period_tick),
`ifdef PWM_RAMP_HOLD_EN
      .hold        (hold),
`endif
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_target  (cfg_target),
      .cfg_step    (cfg_step),
      .cfg_div     (cfg_div),
      .duty_out    (duty_out),
      .busy        (busy),
      .ramp_done   (ramp_done),
      .cfg_err     (cfg_err),
      .overrun     (overrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clock);
      #1;
   endtask

   function automatic int mv(input int c, input int t, input int s);
      if (s == 0) return t;
      if (c < t) return (c + s > t) ? t : c + s;
      if (c > t) return (c - s < t) ? t : c - s;
      return c;
   endfunction

   function automatic logic [VW-1:0] pack_model();
      logic [VW-1:0] v;
      logic [DW-1:0] c;
      v = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = m_cur[i][DW-1:0];
         v[i*DW +: DW] = c;
      end
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] busy_model();
      logic [NUM_CH-1:0] b;
      for (int i = 0; i < NUM_CH; i++) b[i] = (m_cur[i] != m_tgt[i]);
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cur[i] = 0; m_tgt[i] = 0; m_stp[i] = 0; m_div[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_cfg(input int ch, input int t, input int s, input int d);
      if (ch < NUM_CH) begin
         m_tgt[ch] = t; m_stp[ch] = s; m_div[ch] = d; m_cnt[ch] = 0;
      end
   endtask

   task automatic model_sweep(output logic [NUM_CH-1:0] done);
      int n;
      done = '0;
      if (!m_hold) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (m_cnt[i] != m_div[i]) begin
               m_cnt[i]++;
            end else begin
               m_cnt[i] = 0;
               n = mv(m_cur[i], m_tgt[i], m_stp[i]);
               if (n == m_tgt[i] && m_cur[i] != m_tgt[i]) done[i] = 1'b1;
               m_cur[i] = n;
            end
         end
      end
   endtask

   task automatic drive_cfg(input int ch, input int t, input int s, input int d);
      cfg_ch     = ch[3:0];
      cfg_target = t[DW-1:0];
      cfg_step   = s[DW-1:0];
      cfg_div    = d[7:0];
      cfg_valid  = 1'b1;
   endtask

   task automatic do_cfg(input int ch, input int t, input int s, input int d);
      drive_cfg(ch, t, s, d);
      chk("cfg_ready", 64'(cfg_ready), 64'd1);
      step_clk();
      cfg_valid = 1'b0;
      chk("cfg_err", 64'(cfg_err), 64'(ch >= NUM_CH));
      model_cfg(ch, t, s, d);
   endtask

   // One PWM period: tick (optionally with a same-cycle config and/or a dropped tick mid-sweep),
   // verify duty_out holds until the commit edge, then pop and compare the committed result.
   task automatic do_tick(input string tag, input bit with_cfg, input int cch, input int ct,
                          input int cs, input int cd, input bit ovr);
      logic [VW-1:0]     prev;
      logic [VW-1:0]     exp_v;
      logic [NUM_CH-1:0] dexp;
      prev = pack_model();
      period_tick = 1'b1;
      if (with_cfg) drive_cfg(cch, ct, cs, cd);
      step_clk();
      period_tick = 1'b0;
      cfg_valid   = 1'b0;
      if (with_cfg) model_cfg(cch, ct, cs, cd);
      model_sweep(dexp);
      exp_q.push_back(pack_model());
      done_q.push_back(dexp);
      step_clk();
      if (ovr) begin
         period_tick = 1'b1;
         step_clk();
         period_tick = 1'b0;
         chk({tag, "_overrun"}, 64'(overrun), 64'd1);
         repeat (NUM_CH - 2) step_clk();
      end else begin
         repeat (NUM_CH - 1) step_clk();
      end
      chk({tag, "_pre_commit"}, 64'(duty_out), 64'(prev));
      step_clk();
      if (exp_q.size() == 0 || done_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         exp_v = exp_q.pop_front();
         chk({tag, "_duty"}, 64'(duty_out), 64'(exp_v));
         chk({tag, "_ramp_done"}, 64'(ramp_done), 64'(done_q.pop_front()));
         chk({tag, "_busy"}, 64'(busy), 64'(busy_model()));
      end
   endtask

   initial begin
      reset = 1'b1; period_tick = 1'b0; cfg_valid = 1'b0;
      cfg_ch = '0; cfg_target = '0; cfg_step = '0; cfg_div = '0;
`ifdef PWM_RAMP_HOLD_EN
      hold = 1'b0;
`endif
      model_reset();
      repeat (3) step_clk();
      chk("rst_duty", 64'(duty_out), 64'd0);
      chk("rst_ready", 64'(cfg_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(ramp_done), 64'd0);
      reset = 1'b0;
      step_clk();

      for (int k = 0; k < 10; k++) do_tick("idle_tick", 1'b0, 0, 0, 0, 0, 1'b0);

      // Up ramp on ch0.
      do_cfg(0, 100, 30, 0);
      do_tick("up1", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("up1_ch0", 64'(duty_out[0 +: DW]), 64'd30);
      do_tick("up2", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("up2_ch0", 64'(duty_out[0 +: DW]), 64'd60);
      do_tick("up3", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("up3_ch0", 64'(duty_out[0 +: DW]), 64'd90);
      chk("up3_nodone", 64'(ramp_done[0]), 64'd0);
      do_tick("up4", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("up4_ch0", 64'(duty_out[0 +: DW]), 64'd100);
      chk("up4_done", 64'(ramp_done[0]), 64'd1);
      chk("up4_busy", 64'(busy[0]), 64'd0);

      // Jump ch1 to full scale, then a saturating down ramp, then a jump up.
      do_cfg(1, 4095, 0, 0);
      do_tick("jmp_full", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("jmp_full_ch1", 64'(duty_out[DW +: DW]), 64'd4095);
      do_cfg(1, 5, 1000, 0);
      for (int k = 0; k < 5; k++) do_tick("down", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("down_ch1", 64'(duty_out[DW +: DW]), 64'd5);
      chk("down_done", 64'(ramp_done[1]), 64'd1);
      do_cfg(1, 4000, 0, 0);
      do_tick("jmp_up", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("jmp_up_ch1", 64'(duty_out[DW +: DW]), 64'd4000);

      // Prescaled ramp on ch2: moves only every third tick.
      do_cfg(2, 50, 10, 2);
      for (int k = 1; k <= 9; k++) begin
         do_tick("presc", 1'b0, 0, 0, 0, 0, 1'b0);
         if (k == 2) chk("presc_t2_ch2", 64'(duty_out[2*DW +: DW]), 64'd0);
         if (k == 3) chk("presc_t3_ch2", 64'(duty_out[2*DW +: DW]), 64'd10);
         if (k == 6) chk("presc_t6_ch2", 64'(duty_out[2*DW +: DW]), 64'd20);
      end

      // Out-of-range channel: error pulse, no state change.
      do_cfg(7, 1234, 5, 0);
      step_clk();
      chk("cfg_err_clear", 64'(cfg_err), 64'd0);
      do_tick("bad_ch", 1'b0, 0, 0, 0, 0, 1'b0);

      // Tick during a sweep is dropped.
      do_tick("ovr", 1'b0, 0, 0, 0, 0, 1'b1);
      chk("ovr_clear", 64'(overrun), 64'd0);
      do_tick("after_ovr", 1'b0, 0, 0, 0, 0, 1'b0);

      // Config and tick in the same IDLE cycle: new config used by that sweep.
      do_tick("cfg_tick", 1'b1, 3, 300, 0, 0, 1'b0);
      chk("cfg_tick_ch3", 64'(duty_out[3*DW +: DW]), 64'd300);

      // Reset while the sweep is at idx 1.
      do_cfg(0, 2000, 0, 0);
      period_tick = 1'b1;
      step_clk();
      period_tick = 1'b0;
      step_clk();
      reset = 1'b1;
      step_clk();
      reset = 1'b0;
      model_reset();
      chk("mid_rst_duty", 64'(duty_out), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(cfg_ready), 64'd1);
      for (int k = 0; k < NUM_CH + 2; k++) begin
         chk("mid_rst_nodone", 64'(ramp_done), 64'd0);
         chk("mid_rst_nocommit", 64'(duty_out), 64'd0);
         step_clk();
      end

`ifdef PWM_RAMP_HOLD_EN
      do_cfg(0, 1000, 100, 0);
      hold = 1'b1;
      m_hold = 1'b1;
      for (int k = 0; k < 5; k++) do_tick("hold", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("hold_ch0", 64'(duty_out[0 +: DW]), 64'd0);
      hold = 1'b0;
      m_hold = 1'b0;
      do_tick("resume1", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("resume1_ch0", 64'(duty_out[0 +: DW]), 64'd100);
      do_tick("resume2", 1'b0, 0, 0, 0, 0, 1'b0);
      chk("resume2_ch0", 64'(duty_out[0 +: DW]), 64'd200);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
